dec_rr_arbiter: RTL

Round-robin arbiter that shares the 2-to-4 decoder select (A, B) among four requesters. It registers one owner at a time and drives the decoder select lines for that owner. It also outputs the equivalent one-hot grant vector and a valid flag. It bounds tenure with a hold counter, so one requester cannot starve the others.

---
 rtl/dec_rr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dec_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dec_rr_arbiter
//
// Round-robin arbiter that shares a 2-to-4 decoder select among four
// requesters. One owner is registered at a time. Its index is driven on the
// decoder select lines {A,B}, and it is also presented as a one-hot grant.
// A hold counter bounds how long an owner may keep the grant while someone
// else is waiting, so no requester can be starved.
//
// Parameters:
//   HOLD_MAX : maximum consecutive cycles one owner keeps the grant while
//              another requester is pending (legal range 1..255)
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   req    in   4  level-sensitive request lines, req[i] = requester i
//   A      out  1  decoder select MSB, owner index = 2*A + B
//   B      out  1  decoder select LSB
//   gnt    out  4  one-hot grant, all zero when no grant is active
//   valid  out  1  a grant is active this cycle
//   hold   out  8  cycles the current owner has held the grant, minus one
// ---------------------------------------------------------------------------
module dec_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       A,
    output logic       B,
    output logic [3:0] gnt,
    output logic       valid,
    output logic [7:0] hold
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Last value hold may reach. Reaching it with contention forces a handoff.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [3:0] others;
    logic [2:0] idle_pick;
    logic [2:0] next_pick;

    // Round-robin search. Returns {found, index} for the first set bit of r,
    // scanning start, start+1, ... modulo 4. The loop runs from the far end
    // back toward start, so the nearest candidate is written last and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // The registered select lines hold the owner index. When the FSM is idle,
    // they keep the previous owner, and nothing below relies on them in IDLE.
    // The current owner is masked out of the others-search. An owner that
    // releases, or is preempted, is therefore considered only after everyone
    // else.
    always_comb begin
        owner     = {A, B};
        others    = req & ~(4'(1) << owner);
        idle_pick = rr_pick(req, ptr);
        next_pick = rr_pick(others, owner + 2'd1);
    end

    // Single-process FSM with every output registered. A grant in IDLE, a
    // handoff on release and a preemption all take effect on the same edge
    // that detects them. This gives one-edge latency and no bubble cycle
    // between owners.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            A     <= 1'b0;
            B     <= 1'b0;
            gnt   <= 4'b0000;
            valid <= 1'b0;
            hold  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[2]) begin
                        A     <= idle_pick[1];
                        B     <= idle_pick[0];
                        gnt   <= 4'(1) << idle_pick[1:0];
                        valid <= 1'b1;
                        hold  <= 8'd0;
                        state <= GRANT;
                    end
                end

                GRANT: begin
                    if (!req[owner]) begin
                        // The owner has released. The pointer moves past it
                        // whether or not anyone else is waiting.
                        ptr <= owner + 2'd1;
                        if (next_pick[2]) begin
                            A     <= next_pick[1];
                            B     <= next_pick[0];
                            gnt   <= 4'(1) << next_pick[1:0];
                            valid <= 1'b1;
                            hold  <= 8'd0;
                        end else begin
                            gnt   <= 4'b0000;
                            valid <= 1'b0;
                            hold  <= 8'd0;
                            state <= IDLE;
                        end
                    end else if (next_pick[2] && (hold == HOLD_LAST)) begin
                        // Tenure has expired under contention. The owner
                        // still requests, and it rejoins the rotation
                        // behind the others.
                        ptr   <= owner + 2'd1;
                        A     <= next_pick[1];
                        B     <= next_pick[0];
                        gnt   <= 4'(1) << next_pick[1:0];
                        valid <= 1'b1;
                        hold  <= 8'd0;
                    end else if (hold != HOLD_LAST) begin
                        hold <= hold + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
